// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg: shared types and defaults for the prefetching IF stage.  Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_AW      = 16;
  localparam int FETCH_IW      = 16;
  localparam int FETCH_PC_STEP = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_IW-1:0] instr;
    logic [FETCH_AW-1:0] pc_inc;
  } fetch_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo: DEPTH-entry prefetch queue with push/pop/flush.  Rev 1.0
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output T                         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = ptr_width(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          full_w;
  logic          do_push_w;
  logic          do_pop_w;

  assign full_w    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push_w = push_i & ~flush_i & (~full_w | pop_i);
  assign do_pop_w  = pop_i & ~flush_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, do_push_w} - {{PW{1'b0}}, do_pop_w};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_w) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_q.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_prefetch_q: IF stage - PC, blocking imem handshake, prefetch queue.
// FETCH_BYPASS_EN: a response into an empty queue goes straight to decode. Rev 1.0
// ---------------------------------------------------------------------------
module fetch_prefetch_q
  import fetch_pkg::*;
#(
  parameter int            AW       = FETCH_AW,
  parameter int            IW       = FETCH_IW,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            PC_STEP  = FETCH_PC_STEP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          halt_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [AW-1:0] imem_addr_o,
  output logic          imem_rd_o,
  input  logic [IW-1:0] imem_data_i,
  input  logic          imem_done_i,
  input  logic          imem_err_i,
  output logic          instr_valid_o,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] pc_inc_o,
  input  logic          instr_ready_i,
  output logic          nop_o,
  output logic          err_o
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [0:0]    S_IDLE = IDLE;
  localparam logic [0:0]    S_WAIT = WAIT;
  localparam logic [AW-1:0] STEP   = AW'(PC_STEP);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc_inc;
  } entry_t;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          squash_q, squash_d;
  logic          err_q;

  logic [CW-1:0] fifo_count_w;
  logic          fifo_empty_w;
  entry_t        fifo_head_w;
  entry_t        push_entry_w;
  logic          issue_w, resp_w, push_w, pop_w, bypass_w;
  logic [AW-1:0] resp_pc_inc_w;

  assign resp_w        = (state_q == S_WAIT) & imem_done_i;
  assign resp_pc_inc_w = addr_q + STEP;
  // A redirect in IDLE only retargets the PC; the fetch goes out a cycle later.
  assign issue_w       = (state_q == S_IDLE) & en_i & ~halt_i & ~redirect_i &
                         (fifo_count_w < CW'(DEPTH));

`ifdef FETCH_BYPASS_EN
  assign bypass_w = fifo_empty_w & resp_w & ~squash_q & instr_ready_i & ~redirect_i;
`else
  assign bypass_w = 1'b0;
`endif

  assign push_w              = resp_w & ~squash_q & ~redirect_i & ~bypass_w;
  assign pop_w               = instr_valid_o & instr_ready_i & ~redirect_i & ~bypass_w;
  assign push_entry_w.instr  = imem_data_i;
  assign push_entry_w.pc_inc = resp_pc_inc_w;

  always_comb begin
    instr_valid_o = ~fifo_empty_w;
    instr_o       = fifo_head_w.instr;
    pc_inc_o      = fifo_head_w.pc_inc;
    if (bypass_w) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_data_i;
      pc_inc_o      = resp_pc_inc_w;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    squash_d   = squash_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end else if (issue_w) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (imem_done_i) begin
          state_d  = S_IDLE;
          squash_d = 1'b0;
          if (redirect_i)     fetch_pc_d = redirect_pc_i;
          else if (!squash_q) fetch_pc_d = resp_pc_inc_w;
        end else if (redirect_i) begin
          // The miss cannot be aborted; remember to discard its data.
          squash_d   = 1'b1;
          fetch_pc_d = redirect_pc_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      squash_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      squash_q   <= squash_d;
      err_q      <= err_q | imem_err_i;
    end
  end

  assign imem_rd_o   = (state_q == S_WAIT);
  assign imem_addr_o = (state_q == S_WAIT) ? addr_q : fetch_pc_q;
  assign nop_o       = ~instr_valid_o | redirect_i;
  assign err_o       = err_q;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .data_i  (push_entry_w),
    .pop_i   (pop_w),
    .flush_i (redirect_i),
    .head_o  (fifo_head_w),
    .count_o (fifo_count_w),
    .empty_o (fifo_empty_w)
  );

endmodule
`default_nettype wire
